mem_port_arbiter: RTL and testbench

- Shares one `mem_system` cache/memory port between two requesters: instruction fetch (I-side) and data load/store (D-side).
- Each requester sees a mem_system-style interface: addr, data in, rd, wr, data out, done, stall, hit, err.
- The arbiter grants one requester at a time, issues exactly one downstream access, and routes the response back as a single-cycle done pulse.
- Fixed priority favours D-side. A starvation limit guarantees I-side progress, and a timeout catches a hung downstream port.

---
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one mem_system port. D-side wins by default;
// a starvation counter forces an I-side grant, and a timeout aborts hung accesses.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_din,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [15:0] i_dout,
  output logic        i_done,
  output logic        i_stall,
  output logic        i_hit,
  output logic        i_err,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_din,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [15:0] d_dout,
  output logic        d_done,
  output logic        d_stall,
  output logic        d_hit,
  output logic        d_err,
  output logic [15:0] m_addr,
  output logic [15:0] m_din,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_dout,
  input  logic        m_done,
  input  logic        m_hit,
  input  logic        m_err,
  output logic        gnt_d
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        sel_d_q, sel_d_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] i_dout_q, i_dout_d;
  logic        i_hit_q, i_hit_d;
  logic        i_err_q, i_err_d;
  logic [15:0] d_dout_q, d_dout_d;
  logic        d_hit_q, d_hit_d;
  logic        d_err_q, d_err_d;

  logic        i_req;
  logic        d_req;
  logic        fin;
  logic [15:0] fin_dout;
  logic        fin_hit;
  logic        fin_err;

  assign i_req = i_rd | i_wr;
  assign d_req = d_rd | d_wr;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    sel_d_d    = sel_d_q;
    resp_err_d = resp_err_q;
    i_dout_d   = i_dout_q;
    i_hit_d    = i_hit_q;
    i_err_d    = i_err_q;
    d_dout_d   = d_dout_q;
    d_hit_d    = d_hit_q;
    d_err_d    = d_err_q;
    fin        = 1'b0;
    fin_dout   = 16'h0000;
    fin_hit    = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      IDLE: begin
        // D wins unless I has already waited through STARVE_LIMIT D grants
        if (d_req && (!i_req || (starve_q < STARVE_MAX))) begin
          sel_d_d = 1'b1;
          addr_d  = d_addr;
          din_d   = d_din;
          rd_d    = d_rd;
          wr_d    = d_wr;
          state_d = ISSUE;
          if (i_req) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_req) begin
          sel_d_d  = 1'b0;
          addr_d   = i_addr;
          din_d    = i_din;
          rd_d     = i_rd;
          wr_d     = i_wr;
          starve_d = 4'd0;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        tmo_d = tmo_q + 8'd1;
        if (rd_q && wr_q) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (m_done) begin
          fin      = 1'b1;
          fin_dout = m_dout;
          fin_hit  = m_hit;
          fin_err  = resp_err_q | m_err;
        end else if (tmo_q == TMO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          resp_err_d = resp_err_q | m_err;
        end
      end

      RESP: begin
        state_d    = IDLE;
        tmo_d      = 8'd0;
        resp_err_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Response payload goes straight into the winner's holding registers
    if (fin) begin
      state_d = RESP;
      if (sel_d_q) begin
        d_dout_d = fin_dout;
        d_hit_d  = fin_hit;
        d_err_d  = fin_err;
      end else begin
        i_dout_d = fin_dout;
        i_hit_d  = fin_hit;
        i_err_d  = fin_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      tmo_q      <= 8'd0;
      addr_q     <= 16'h0000;
      din_q      <= 16'h0000;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      sel_d_q    <= 1'b0;
      resp_err_q <= 1'b0;
      i_dout_q   <= 16'h0000;
      i_hit_q    <= 1'b0;
      i_err_q    <= 1'b0;
      d_dout_q   <= 16'h0000;
      d_hit_q    <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      sel_d_q    <= sel_d_d;
      resp_err_q <= resp_err_d;
      i_dout_q   <= i_dout_d;
      i_hit_q    <= i_hit_d;
      i_err_q    <= i_err_d;
      d_dout_q   <= d_dout_d;
      d_hit_q    <= d_hit_d;
      d_err_q    <= d_err_d;
    end
  end

  // Rd/Wr fall in the Done cycle so mem_system does not start a second access
  assign m_addr = addr_q;
  assign m_din  = din_q;
  assign m_rd   = (state_q == ISSUE) & rd_q & ~wr_q & ~m_done;
  assign m_wr   = (state_q == ISSUE) & wr_q & ~rd_q & ~m_done;

  assign i_done  = (state_q == RESP) & ~sel_d_q;
  assign d_done  = (state_q == RESP) & sel_d_q;
  assign i_stall = rst & i_req & ~i_done;
  assign d_stall = rst & d_req & ~d_done;

  assign i_dout = i_dout_q;
  assign i_hit  = i_hit_q;
  assign i_err  = i_err_q;
  assign d_dout = d_dout_q;
  assign d_hit  = d_hit_q;
  assign d_err  = d_err_q;
  assign gnt_d  = sel_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model
// of the grant order, starvation rule and downstream responses.
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, i_din, i_dout;
  logic        i_rd, i_wr, i_done, i_stall, i_hit, i_err;
  logic [15:0] d_addr, d_din, d_dout;
  logic        d_rd, d_wr, d_done, d_stall, d_hit, d_err;
  logic [15:0] m_addr, m_din, m_dout;
  logic        m_rd, m_wr, m_done, m_hit, m_err, gnt_d;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_din(i_din), .i_rd(i_rd), .i_wr(i_wr), .i_dout(i_dout),
    .i_done(i_done), .i_stall(i_stall), .i_hit(i_hit), .i_err(i_err),
    .d_addr(d_addr), .d_din(d_din), .d_rd(d_rd), .d_wr(d_wr), .d_dout(d_dout),
    .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit), .d_err(d_err),
    .m_addr(m_addr), .m_din(m_din), .m_rd(m_rd), .m_wr(m_wr), .m_dout(m_dout),
    .m_done(m_done), .m_hit(m_hit), .m_err(m_err), .gnt_d(gnt_d)
  );

  typedef struct {
    logic        side;
    logic [15:0] addr;
    logic [15:0] din;
    logic        rd;
    logic        wr;
  } req_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] dn_mem  [16];
  logic [15:0] ref_mem [16];
  int lat_cnt = 0;
  int lat_target = 1;
  int starve_m = 0;
  req_t dq[$];
  req_t exp_q[$];
  req_t irec, e;
  int n, cyc, cnt, di, got, total, nd, ni, k;
  logic [15:0] ed;
  logic eh, ee;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Downstream memory: random 1..4 cycle latency, hit when address is odd
  task automatic auto_resp();
    logic acc_wr;
    acc_wr = m_wr;
    if (m_done) begin
      m_done = 1'b0;
      m_hit  = 1'b0;
    end else if (m_rd || m_wr) begin
      lat_cnt++;
      if (lat_cnt >= lat_target) begin
        m_dout = dn_mem[m_addr[3:0]];
        m_hit  = m_addr[0];
        if (acc_wr) dn_mem[m_addr[3:0]] = m_din;
        m_done = 1'b1;
        lat_cnt = 0;
        lat_target = $urandom_range(1, 4);
      end
    end
  endtask

  function automatic req_t rnd_req(input logic side);
    req_t r;
    int sel;
    r.side = side;
    r.addr = 16'($urandom);
    r.din  = 16'($urandom);
    sel    = $urandom_range(0, 7);
    r.rd   = (sel < 4) || (sel == 7);
    r.wr   = (sel >= 4);
    return r;
  endfunction

  task automatic drive_d(input req_t r);
    d_addr = r.addr; d_din = r.din; d_rd = r.rd; d_wr = r.wr;
  endtask

  task automatic drive_i(input req_t r);
    i_addr = r.addr; i_din = r.din; i_rd = r.rd; i_wr = r.wr;
  endtask

  task automatic idle_d();
    d_addr = 16'h0; d_din = 16'h0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic idle_i();
    i_addr = 16'h0; i_din = 16'h0; i_rd = 1'b0; i_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_i();
    idle_d();
    m_dout = 16'h0; m_done = 1'b0; m_hit = 1'b0; m_err = 1'b0;
    for (int a = 0; a < 16; a++) begin
      dn_mem[a]  = 16'hA000 + 16'(a);
      ref_mem[a] = 16'hA000 + 16'(a);
    end

    // Reset state
    repeat (2) tick();
    check1("rst_i_done", i_done, 1'b0);
    check1("rst_d_done", d_done, 1'b0);
    check1("rst_m_rd", m_rd, 1'b0);
    check1("rst_gnt_d", gnt_d, 1'b0);
    check16("rst_m_addr", m_addr, 16'h0);
    check16("rst_i_dout", i_dout, 16'h0);
    rst = 1'b1;
    tick();

    // I-side read alone, downstream done on the 4th ISSUE cycle
    i_rd = 1'b1; i_addr = 16'h0040;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check1("t1_m_rd_high", m_rd, 1'b1);
      check16("t1_m_addr", m_addr, 16'h0040);
    end
    m_done = 1'b1; m_dout = 16'hBEEF; m_hit = 1'b1;
    #1 check1("t1_m_rd_low_in_done", m_rd, 1'b0);
    tick();
    m_done = 1'b0; m_hit = 1'b0;
    check1("t1_i_done", i_done, 1'b1);
    check16("t1_i_dout", i_dout, 16'hBEEF);
    check1("t1_i_hit", i_hit, 1'b1);
    check1("t1_i_err", i_err, 1'b0);
    check1("t1_d_done", d_done, 1'b0);
    check1("t1_i_stall", i_stall, 1'b0);
    idle_i();
    tick();
    check1("t1_done_single", i_done, 1'b0);
    check16("t1_dout_hold", i_dout, 16'hBEEF);

    // Simultaneous D write and I read: D first
    d_wr = 1'b1; d_addr = 16'h1000; d_din = 16'h5555;
    i_rd = 1'b1; i_addr = 16'h0002;
    tick();
    check1("t2_m_wr", m_wr, 1'b1);
    check1("t2_m_rd", m_rd, 1'b0);
    check16("t2_m_din", m_din, 16'h5555);
    check16("t2_m_addr", m_addr, 16'h1000);
    check1("t2_gnt_d", gnt_d, 1'b1);
    check1("t2_i_stall_wait", i_stall, 1'b1);
    tick();
    m_done = 1'b1; m_dout = 16'h0000; m_hit = 1'b0;
    tick();
    m_done = 1'b0;
    check1("t2_d_done", d_done, 1'b1);
    check1("t2_i_not_done", i_done, 1'b0);
    idle_d();
    tick();
    check1("t2_idle_no_rd", m_rd, 1'b0);
    tick();
    check1("t2_i_issued", m_rd, 1'b1);
    check16("t2_i_addr", m_addr, 16'h0002);
    check1("t2_gnt_i", gnt_d, 1'b0);
    m_done = 1'b1; m_dout = 16'h1234; m_hit = 1'b1;
    tick();
    m_done = 1'b0; m_hit = 1'b0;
    check1("t2_i_done", i_done, 1'b1);
    check1("t2_d_quiet", d_done, 1'b0);
    check16("t2_i_dout", i_dout, 16'h1234);
    idle_i();
    tick();

    // Starvation: D and I held continuously
    lat_cnt = 0; lat_target = 1;
    d_rd = 1'b1; d_addr = 16'h0010;
    i_rd = 1'b1; i_addr = 16'h0020;
    n = 0; cyc = 0;
    while (n < 2 * (STARVE_LIMIT + 1) && cyc < 1000) begin
      tick(); cyc++;
      auto_resp();
      if (i_done || d_done) begin
        check1("starve_order", d_done, (n % (STARVE_LIMIT + 1)) != STARVE_LIMIT);
        n++;
      end
    end
    checkn("starve_count", n, 2 * (STARVE_LIMIT + 1));
    idle_d();
    idle_i();
    tick();

    // Timeout: downstream never completes
    i_rd = 1'b1; i_addr = 16'h0100;
    cnt = 0; cyc = 0;
    while (!i_done && cyc < 400) begin
      tick(); cyc++;
      if (m_rd) cnt++;
    end
    checkn("tmo_rd_cycles", cnt, TIMEOUT);
    check1("tmo_i_done", i_done, 1'b1);
    check1("tmo_i_err", i_err, 1'b1);
    check16("tmo_i_dout", i_dout, 16'h0);
    idle_i();
    tick();
    i_rd = 1'b1; i_addr = 16'h0200;
    tick();
    check1("tmo_next_rd", m_rd, 1'b1);
    m_done = 1'b1; m_dout = 16'h7777; m_hit = 1'b0;
    tick();
    m_done = 1'b0;
    check1("tmo_next_done", i_done, 1'b1);
    check1("tmo_next_err", i_err, 1'b0);
    check16("tmo_next_dout", i_dout, 16'h7777);
    idle_i();
    tick();

    // rd=wr=1 on D: no downstream access, error response
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0300;
    tick();
    check1("rw_no_access", m_rd | m_wr, 1'b0);
    check1("rw_not_yet", d_done, 1'b0);
    tick();
    check1("rw_d_done", d_done, 1'b1);
    check1("rw_d_err", d_err, 1'b1);
    check16("rw_d_dout", d_dout, 16'h0);
    check1("rw_d_hit", d_hit, 1'b0);
    idle_d();
    tick();

    // m_err pulse mid-access is sticky into the response
    d_rd = 1'b1; d_addr = 16'h0400;
    tick();
    m_err = 1'b1;
    tick();
    m_err = 1'b0;
    tick();
    m_done = 1'b1; m_dout = 16'h4321; m_hit = 1'b1;
    tick();
    m_done = 1'b0; m_hit = 1'b0;
    check1("merr_d_done", d_done, 1'b1);
    check1("merr_d_err", d_err, 1'b1);
    check16("merr_d_dout", d_dout, 16'h4321);
    idle_d();
    tick();
    d_rd = 1'b1; d_addr = 16'h0500;
    tick();
    m_done = 1'b1; m_dout = 16'h1111;
    tick();
    m_done = 1'b0;
    check1("merr_cleared", d_err, 1'b0);
    idle_d();
    tick();

    // Asynchronous reset in the middle of a D access, I pending
    d_rd = 1'b1; d_addr = 16'h0600;
    i_rd = 1'b1; i_addr = 16'h0700;
    tick();
    check1("ar_d_issue", m_rd, 1'b1);
    check1("ar_gnt_before", gnt_d, 1'b1);
    #2 rst = 1'b0;
    idle_d();
    #1;
    check1("ar_m_rd", m_rd, 1'b0);
    check1("ar_gnt_d", gnt_d, 1'b0);
    check16("ar_d_dout", d_dout, 16'h0);
    check16("ar_i_dout", i_dout, 16'h0);
    check16("ar_m_addr", m_addr, 16'h0);
    check1("ar_i_stall", i_stall, 1'b0);
    tick();
    check1("ar_no_d_done", d_done, 1'b0);
    rst = 1'b1;
    tick();
    check1("ar_i_granted", m_rd, 1'b1);
    check16("ar_i_addr", m_addr, 16'h0700);
    check1("ar_no_d_done2", d_done, 1'b0);
    m_done = 1'b1; m_dout = 16'h2222;
    tick();
    m_done = 1'b0;
    check1("ar_i_done", i_done, 1'b1);
    check16("ar_i_dout", i_dout, 16'h2222);
    idle_i();
    tick();

    // Randomized batches against the transaction-level model
    lat_cnt = 0; lat_target = 1; starve_m = 0;
    for (int b = 0; b < 40; b++) begin
      nd = $urandom_range(0, 6);
      ni = $urandom_range(0, 1);
      if (nd == 0) ni = 1;
      dq.delete();
      exp_q.delete();
      for (int j = 0; j < nd; j++) dq.push_back(rnd_req(1'b1));
      irec = rnd_req(1'b0);
      k = nd;
      if (ni == 1 && (STARVE_LIMIT - starve_m) < k) k = STARVE_LIMIT - starve_m;
      for (int j = 0; j < k; j++) exp_q.push_back(dq[j]);
      if (ni == 1) exp_q.push_back(irec);
      for (int j = k; j < nd; j++) exp_q.push_back(dq[j]);
      if (ni == 1) starve_m = 0;

      if (nd > 0) drive_d(dq[0]);
      if (ni == 1) drive_i(irec);
      di = 0; got = 0; total = nd + ni; cyc = 0;
      while (got < total && cyc < 400) begin
        tick(); cyc++;
        auto_resp();
        if (cyc == 1) check1("rnd_i_stall", i_stall, ni == 1);
        if (i_done || d_done) begin
          check1("rnd_one_done", i_done & d_done, 1'b0);
          e = exp_q.pop_front();
          check1("rnd_side", d_done, e.side);
          if (e.rd && e.wr) begin
            ed = 16'h0; eh = 1'b0; ee = 1'b1;
          end else begin
            ed = ref_mem[e.addr[3:0]]; eh = e.addr[0]; ee = 1'b0;
            if (e.wr) ref_mem[e.addr[3:0]] = e.din;
          end
          check16("rnd_dout", d_done ? d_dout : i_dout, ed);
          check1("rnd_hit", d_done ? d_hit : i_hit, eh);
          check1("rnd_err", d_done ? d_err : i_err, ee);
          check1("rnd_stall_at_done", d_done ? d_stall : i_stall, 1'b0);
          got++;
          if (d_done) begin
            di++;
            if (di < nd) drive_d(dq[di]);
            else idle_d();
          end else begin
            idle_i();
          end
        end
      end
      checkn("rnd_complete", got, total);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
